mc_control_fsm: RTL and testbench

Multicycle successor to the single-cycle MIPS control decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and issues Moore-style datapath controls per state. Memory accesses stall on a `mem_ready` handshake, guarded by a watchdog. It sits between the instruction register opcode field and the shared multicycle datapath: PC, IR, register file, ALU and unified memory.

---
 rtl/mc_control_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control sequencer.
// Each instruction passes through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
// The FSM issues Moore-style datapath controls for each state. Memory states
// stall on mem_ready, and a watchdog aborts a stall that runs too long.
//
// Optional feature: define MC_BNE_EN to accept bne (opcode 000101). That build
// also adds the branch_ne output.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   opcode[5:0]           instruction[31:26], sampled in DECODE
//   mem_ready             memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//   pc_source[1:0]        datapath controls, decoded from the current state
//   illegal_op            sticky flag: an unsupported opcode was decoded
//   mem_timeout           one-cycle pulse after a watchdog abort
//   state_dbg[3:0]        current state encoding
//   branch_ne             (MC_BNE_EN only) BR state is executing bne
module mc_control_fsm #(
    parameter bit          USE_MEM_READY  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
`ifdef MC_BNE_EN
    ,
    output logic       branch_ne
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BR       = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JMP      = 4'd11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_cnt_nxt;
    logic             set_illegal;
    logic             ready;
    logic             wait_state;
    logic             timeout;

    // A single-cycle memory build behaves as if every access completes at once.
    assign ready      = USE_MEM_READY ? mem_ready : 1'b1;
    assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // A ready that arrives on the limit cycle still wins over the abort.
    assign timeout    = WD_EN && wait_state && !ready && (wd_cnt == WD_LIMIT);
    assign state_dbg  = state;

    // State register, captured opcode, watchdog counter and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            op_q        <= '0;
            wd_cnt      <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wd_cnt      <= wd_cnt_nxt;
            illegal_op  <= illegal_op | set_illegal;
            mem_timeout <= timeout;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state, illegal-opcode and watchdog-counter logic.
    always_comb begin
        state_nxt   = state;
        set_illegal = 1'b0;
        wd_cnt_nxt  = '0;

        case (state)
            S_FETCH: begin
                if (timeout)    state_nxt = S_FETCH;
                else if (ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_RTYPE:     state_nxt = S_R_EXEC;
                    OP_BEQ:       state_nxt = S_BR;
`ifdef MC_BNE_EN
                    OP_BNE:       state_nxt = S_BR;
`endif
                    OP_ADDI:      state_nxt = S_ADDI_EX;
                    OP_J:         state_nxt = S_JMP;
                    default: begin
                        state_nxt   = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            // Only lw and sw reach MEM_ADDR, so any non-lw opcode here is a store.
            S_MEM_ADDR: state_nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (timeout)    state_nxt = S_FETCH;
                else if (ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: state_nxt = S_FETCH;
            S_MEM_WR: begin
                if (timeout)    state_nxt = S_FETCH;
                else if (ready) state_nxt = S_FETCH;
            end
            S_R_EXEC:  state_nxt = S_R_WB;
            S_R_WB:    state_nxt = S_FETCH;
            S_BR:      state_nxt = S_FETCH;
            S_ADDI_EX: state_nxt = S_ADDI_WB;
            S_ADDI_WB: state_nxt = S_FETCH;
            S_JMP:     state_nxt = S_FETCH;
            default:   state_nxt = S_FETCH;
        endcase

        // Count only consecutive stalled cycles within one wait state.
        if (WD_EN && wait_state && !ready && !timeout && (state_nxt == state)) begin
            wd_cnt_nxt = wd_cnt + CNT_W'(1);
        end
    end

    // Moore control decode; the FETCH loads follow the memory handshake.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
`ifdef MC_BNE_EN
        branch_ne     = 1'b0;
`endif

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_write  = ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BR: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
`ifdef MC_BNE_EN
                branch_ne     = (op_q == OP_BNE);
`endif
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: self-checking bench for mc_control_fsm.
// The reference model represents each decoded instruction as a queue of the
// states it still has to visit. Memory states wait on mem_ready under a
// watchdog. The expected controls come from a per-state table. Directed
// sequences with literal state traces pin the model, and a randomized stream
// follows them.
module tb_mc_control_fsm;

    localparam int unsigned TMO = 4;
    localparam logic [5:0] OP_TAB [7] = '{6'b100011, 6'b101011, 6'b000000,
                                          6'b000100, 6'b001000, 6'b000010, 6'b000101};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, mem_timeout;
    logic [3:0] state_dbg;
`ifdef MC_BNE_EN
    logic       branch_ne;
`endif
    logic [15:0] dut_ctrl;

    mc_control_fsm #(
        .USE_MEM_READY (1'b1),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .illegal_op   (illegal_op),
        .mem_timeout  (mem_timeout),
        .state_dbg    (state_dbg)
`ifdef MC_BNE_EN
        ,
        .branch_ne    (branch_ne)
`endif
    );

    always #5 clk = ~clk;

    assign dut_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    int m_cur = 0;
    int m_plan[$];
    int m_wd = 0;
    bit m_ill = 1'b0;
    bit m_tmo = 1'b0;
    bit m_bne = 1'b0;

    // Observed traces for the directed sequences.
    int tr_state[$];
    bit tr_tmo[$];

    // Control vector each state must drive, in dut_ctrl bit order.
    function automatic logic [15:0] exp_ctrl(input int st, input bit rdy);
        bit pcw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa;
        bit [1:0] sb, aop, psrc;
        pcw = 0; pwc = 0; iod = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
        rdst = 0; rw = 0; sa = 0; sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin pcw = rdy; irw = rdy; mrd = 1; sb = 2'b01; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin pcw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {pcw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, psrc};
    endfunction

    task automatic check(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
        end
    endtask

    // Advance the model across one clock edge with the inputs that were applied.
    task automatic model_update(input bit r, input logic [5:0] op, input bit rdy);
        if (!r) begin
            m_cur = 0; m_plan.delete(); m_wd = 0; m_ill = 0; m_tmo = 0; m_bne = 0;
            return;
        end
        m_tmo = 0;
        if (m_cur == 0 || m_cur == 3 || m_cur == 5) begin
            if (rdy) begin
                m_wd  = 0;
                m_cur = (m_cur == 0) ? 1 : ((m_plan.size() > 0) ? m_plan.pop_front() : 0);
            end else if (TMO > 0 && m_wd == int'(TMO) - 1) begin
                m_wd = 0; m_plan.delete(); m_cur = 0; m_tmo = 1;
            end else begin
                m_wd++;
            end
        end else if (m_cur == 1) begin
            m_plan.delete();
            m_bne = 0;
            case (op)
                6'b100011: begin m_plan.push_back(2); m_plan.push_back(3); m_plan.push_back(4); end
                6'b101011: begin m_plan.push_back(2); m_plan.push_back(5); end
                6'b000000: begin m_plan.push_back(6); m_plan.push_back(7); end
                6'b000100: m_plan.push_back(8);
`ifdef MC_BNE_EN
                6'b000101: begin m_plan.push_back(8); m_bne = 1; end
`endif
                6'b001000: begin m_plan.push_back(9); m_plan.push_back(10); end
                6'b000010: m_plan.push_back(11);
                default:   m_ill = 1;
            endcase
            m_cur = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
        end else begin
            m_cur = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
        end
    endtask

    // One clock: drive at negedge, compare against the model, then step the model.
    task automatic cycle(input bit r, input logic [5:0] op, input bit rdy);
        @(negedge clk);
        rst_n = r; opcode = op; mem_ready = rdy;
        #1;
        check("state_dbg", int'(state_dbg), m_cur);
        check("controls", int'(dut_ctrl), int'(exp_ctrl(m_cur, rdy)));
        check("illegal_op", int'(illegal_op), int'(m_ill));
        check("mem_timeout", int'(mem_timeout), int'(m_tmo));
`ifdef MC_BNE_EN
        check("branch_ne", int'(branch_ne), int'(m_cur == 8 && m_bne));
`endif
        tr_state.push_back(int'(state_dbg));
        tr_tmo.push_back(mem_timeout);
        @(posedge clk);
        model_update(r, op, rdy);
    endtask

    // Run n cycles of one opcode; rdy and the expected traces list the first cycle at the MSB.
    task automatic run_seq(input string nm, input logic [5:0] op, input int n,
                           input logic [15:0] rdy, input logic [63:0] want_st,
                           input logic [15:0] want_tmo);
        tr_state.delete();
        tr_tmo.delete();
        for (int i = 0; i < n; i++) cycle(1'b1, op, rdy[n-1-i]);
        for (int i = 0; i < n; i++) begin
            check({nm, "_state"}, tr_state[i], int'(want_st[4*(n-1-i) +: 4]));
            check({nm, "_tmo"}, int'(tr_tmo[i]), int'(want_tmo[n-1-i]));
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        model_update(1'b0, 6'd0, 1'b1);
        #1;
        check("reset_state", int'(state_dbg), 0);
        check("reset_illegal", int'(illegal_op), 0);
        check("reset_timeout", int'(mem_timeout), 0);

        run_seq("rtype", 6'b000000, 5, 16'b11110, 64'h01670, 16'h0);
        check("rtype_illegal", int'(illegal_op), 0);
        run_seq("lw_wait", 6'b100011, 9, 16'b111000110, 64'h012333340, 16'h0);
        run_seq("beq", 6'b000100, 4, 16'b1110, 64'h0180, 16'h0);
        run_seq("illegal", 6'b111111, 3, 16'b110, 64'h010, 16'h0);
        check("illegal_set", int'(illegal_op), 1);
        run_seq("lw_after_ill", 6'b100011, 6, 16'b111110, 64'h012340, 16'h0);
        check("illegal_sticky", int'(illegal_op), 1);
        cycle(1'b0, 6'd0, 1'b1);
        #1;
        check("illegal_cleared", int'(illegal_op), 0);

        run_seq("sw_timeout", 6'b101011, 8, 16'b11100000, 64'h01255550, 16'b00000001);
        run_seq("sw_late_rdy", 6'b101011, 8, 16'b11100010, 64'h01255550, 16'b00000000);
        run_seq("fetch_timeout", 6'b000000, 4, 16'b0000, 64'h0000, 16'b0001);

        run_seq("lw_pre_rst", 6'b100011, 4, 16'b1110, 64'h0123, 16'h0);
        cycle(1'b0, 6'b100011, 1'b0);
        #1;
        check("rst_mid_state", int'(state_dbg), 0);
        check("rst_mid_wr", int'(mem_write), 0);
        check("rst_mid_regw", int'(reg_write), 0);
        check("rst_mid_tmo", int'(mem_timeout), 0);
        run_seq("post_rst_wd", 6'b000000, 6, 16'b000111, 64'h000016, 16'h0);
        cycle(1'b1, 6'b000000, 1'b1);
        cycle(1'b1, 6'b000000, 1'b0);

`ifdef MC_BNE_EN
        run_seq("bne", 6'b000101, 4, 16'b1110, 64'h0180, 16'h0);
        check("bne_legal", int'(illegal_op), 0);
`endif

        for (int i = 0; i < 4000; i++) begin
            bit r, rdy;
            logic [5:0] op;
            r = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 9) < 8) op = OP_TAB[$urandom_range(0, 6)];
            else op = 6'($urandom);
            if (i < 2000) rdy = ($urandom_range(0, 3) != 0);
            else rdy = 1'($urandom_range(0, 1));
            cycle(r, op, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
